decoder_nto2n_seq: RTL and testbench

//  Parametrised, registered N-to-2^N one-hot decoder; successor to the fixed 3-to-8 combinational decoder.
//  Two modes: DIRECT (decode a handshaked select word) and SCAN (self-sequencing walk across all outputs

---
 rtl/decoder_nto2n_seq_if.sv | 29 ++
 rtl/decoder_nto2n_seq.sv | 110 +++++++++++
 tb/tb_decoder_nto2n_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/decoder_nto2n_seq_if.sv
// Handshake/bus bundle for the N-to-2^N sequencing decoder.
// master = stimulus side, slave = decoder side.
interface decoder_nto2n_seq_if #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned DWELL_W = 4
);
    localparam int unsigned OUT_W = 1 << SEL_W;

    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic               sel_ready;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   dec_out;
    logic               out_valid;
    logic [SEL_W-1:0]   scan_idx;
    logic               scan_wrap;

    modport master (
        output en, mode, sel, sel_valid, dwell,
        input  sel_ready, dec_out, out_valid, scan_idx, scan_wrap
    );

    modport slave (
        input  en, mode, sel, sel_valid, dwell,
        output sel_ready, dec_out, out_valid, scan_idx, scan_wrap
    );
endinterface

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with DIRECT (handshaked select) and SCAN (self-walking) modes.
// Define DECODER_ACTLOW_EN for an active-low dec_out (idle value all-ones).
module decoder_nto2n_seq #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned DWELL_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    decoder_nto2n_seq_if.slave  bus
);
    localparam int unsigned OUT_W = 1 << SEL_W;

`ifdef DECODER_ACTLOW_EN
    localparam logic [OUT_W-1:0] IDLE_VAL = '1;
`else
    localparam logic [OUT_W-1:0] IDLE_VAL = '0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   dec_q, dec_d;
    logic               valid_q, valid_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_load_c;
    logic [SEL_W-1:0]   idx_inc_c;
    logic               sel_ready_c;

    // Selected bit flipped away from the idle level, so polarity lives in one place.
    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
        return IDLE_VAL ^ (OUT_W'(1) << i);
    endfunction

    assign sel_ready_c  = (state_q == ST_DIRECT) & bus.en & ~bus.mode;
    assign dwell_load_c = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
    assign idx_inc_c    = idx_q + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dec_q   <= IDLE_VAL;
            valid_q <= 1'b0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;

        if (!bus.en) begin
            state_d = ST_IDLE;
            dec_d   = IDLE_VAL;
            valid_d = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (bus.mode) begin
            if (state_q != ST_SCAN) begin
                // Fresh scan entry: restart at index 0 with a full dwell.
                state_d = ST_SCAN;
                idx_d   = '0;
                cnt_d   = dwell_load_c;
                dec_d   = onehot('0);
                valid_d = 1'b1;
            end else if (cnt_q <= DWELL_W'(1)) begin
                idx_d   = idx_inc_c;
                cnt_d   = dwell_load_c;
                dec_d   = onehot(idx_inc_c);
                valid_d = 1'b1;
                wrap_d  = (idx_q == SEL_W'(OUT_W - 1));
            end else begin
                cnt_d   = cnt_q - DWELL_W'(1);
            end
        end else begin
            // DIRECT: output holds until a transfer replaces it.
            state_d = ST_DIRECT;
            idx_d   = '0;
            cnt_d   = '0;
            if (bus.sel_valid && sel_ready_c) begin
                dec_d   = onehot(bus.sel);
                valid_d = 1'b1;
            end
        end
    end

    assign bus.sel_ready = sel_ready_c;
    assign bus.dec_out   = dec_q;
    assign bus.out_valid = valid_q;
    assign bus.scan_idx  = idx_q;
    assign bus.scan_wrap = wrap_q;
endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Directed + randomized bench for decoder_nto2n_seq against a cycle-level reference model.
// Honours DECODER_ACTLOW_EN by inverting the expected dec_out.
module tb_decoder_nto2n_seq;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned DWELL_W = 4;
    localparam int          OUT_W   = 8;

`ifdef DECODER_ACTLOW_EN
    localparam logic [7:0] IDLE_V = 8'hFF;
`else
    localparam logic [7:0] IDLE_V = 8'h00;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decoder_nto2n_seq_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

    decoder_nto2n_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: 0 = idle, 1 = direct, 2 = scan; m_out = hot index or -1.
    int m_st, m_out, m_ov, m_idx, m_left, m_wrap;

    function automatic logic [7:0] exp_dec(input int o);
        logic [7:0] v;
        v = (o < 0) ? 8'h00 : 8'(1 << o);
        return v ^ IDLE_V;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_out = -1; m_ov = 0; m_idx = 0; m_left = 0; m_wrap = 0;
    endtask

    task automatic model_step();
        int dw;
        int rdy;
        dw  = (bus.dwell == 0) ? 1 : int'(bus.dwell);
        rdy = (m_st == 1 && bus.en && !bus.mode) ? 1 : 0;
        m_wrap = 0;
        if (!bus.en) begin
            model_reset();
        end else if (bus.mode) begin
            if (m_st != 2) begin
                m_st = 2; m_idx = 0; m_left = dw;
            end else if (m_left <= 1) begin
                if (m_idx == OUT_W - 1) m_wrap = 1;
                m_idx  = (m_idx + 1) % OUT_W;
                m_left = dw;
            end else begin
                m_left = m_left - 1;
            end
            m_out = m_idx;
            m_ov  = 1;
        end else begin
            m_st = 1; m_idx = 0;
            if (rdy == 1 && bus.sel_valid) begin
                m_out = int'(bus.sel);
                m_ov  = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/dec_out"},   32'(bus.dec_out),   32'(exp_dec(m_out)));
        check({tag, "/out_valid"}, 32'(bus.out_valid), 32'(m_ov));
        check({tag, "/scan_idx"},  32'(bus.scan_idx),  32'(m_idx));
        check({tag, "/scan_wrap"}, 32'(bus.scan_wrap), 32'(m_wrap));
        check({tag, "/onehot"},    32'($countones(bus.dec_out ^ IDLE_V) <= 1), 32'(1));
    endtask

    task automatic drive(input logic en, input logic mode, input logic [2:0] sel,
                         input logic valid, input logic [3:0] dwell);
        bus.en = en; bus.mode = mode; bus.sel = sel; bus.sel_valid = valid; bus.dwell = dwell;
    endtask

    // One clock: check the combinational ready, advance the model, compare after the edge.
    task automatic cyc(input string tag);
        #1;
        check({tag, "/sel_ready"}, 32'(bus.sel_ready),
              32'((m_st == 1 && bus.en && !bus.mode) ? 1 : 0));
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int b2b [3];
        int wraps;
        int n;
        b2b = '{0, 7, 2};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 1'b0, 4'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Single DIRECT transfer, then hold.
        drive(1'b1, 1'b0, 3'd0, 1'b0, 4'd0);
        cyc("idle_to_direct");
        drive(1'b1, 1'b0, 3'd6, 1'b1, 4'd0);
        cyc("direct_sel6");
        check("direct_sel6_lit", 32'(bus.dec_out), 32'(8'h40 ^ IDLE_V));
        bus.sel_valid = 1'b0;
        cyc("direct_hold0");
        cyc("direct_hold1");
        check("direct_hold_lit", 32'(bus.dec_out), 32'(8'h40 ^ IDLE_V));

        // Back-to-back transfers.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 3'(b2b[i]), 1'b1, 4'd0);
            cyc("direct_b2b");
            check("direct_b2b_lit", 32'(bus.dec_out), 32'(8'(1 << b2b[i]) ^ IDLE_V));
        end

        // SCAN with dwell 2: two wraps in 32 cycles after entry.
        drive(1'b1, 1'b1, 3'd0, 1'b0, 4'd2);
        cyc("scan_entry");
        check("scan_entry_lit", 32'(bus.dec_out), 32'(8'h01 ^ IDLE_V));
        wraps = 0;
        repeat (32) begin
            cyc("scan_d2");
            if (bus.scan_wrap) wraps++;
        end
        check("scan_wrap_count", 32'(wraps), 32'(2));
        bus.dwell = 4'd0;
        repeat (10) cyc("scan_d0");

        // en drop at index 3, then restart at 0.
        n = 0;
        while (m_idx != 3 && n < 64) begin
            cyc("scan_to3");
            n++;
        end
        if (n >= 64) check("scan_to3_timeout", 32'(m_idx), 32'(3));
        bus.en = 1'b0;
        cyc("en_drop");
        check("en_drop_lit", 32'(bus.dec_out), 32'(IDLE_V));
        drive(1'b1, 1'b1, 3'd0, 1'b0, 4'd1);
        cyc("scan_restart");
        check("scan_restart_idx", 32'(bus.scan_idx), 32'(0));

        // SCAN -> DIRECT with a select presented during the switch cycle.
        bus.dwell = 4'd3;
        repeat (5) cyc("scan_d3");
        drive(1'b1, 1'b0, 3'd1, 1'b1, 4'd3);
        cyc("switch");
        cyc("switch_accept");
        check("switch_accept_lit", 32'(bus.dec_out), 32'(8'h02 ^ IDLE_V));

        // Async reset mid-SCAN at index 5, observed with no clock edge.
        drive(1'b1, 1'b1, 3'd0, 1'b0, 4'd1);
        n = 0;
        while (m_idx != 5 && n < 64) begin
            cyc("scan_to5");
            n++;
        end
        if (n >= 64) check("scan_to5_timeout", 32'(m_idx), 32'(5));
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("async_reset");
        check("async_reset_lit", 32'(bus.dec_out), 32'(IDLE_V));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic.
        repeat (400) begin
            bus.en        = ($urandom % 10) != 0;
            if ($urandom % 8 == 0) bus.mode = ~bus.mode;
            bus.sel       = 3'($urandom);
            bus.sel_valid = 1'($urandom);
            bus.dwell     = 4'($urandom);
            cyc("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
